mem_stage: RTL

- Pipeline stage directly downstream of the execute stage in the 16-bit processor.
- Owns the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake.
- Resolves branches from the registered ALU zero flag and branch target, and produces the MEM/WB pipeline register for writeback.
- Stalls the upstream pipeline while a variable-latency memory access is outstanding; a timeout aborts hung accesses.

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_stage_if #(
   parameter int unsigned DATA_W = 16
);
   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake with timeout,
// branch resolution and MEM/WB register.
module mem_stage #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned REG_AW      = 3,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regWrite3,
   input  logic              memtoReg3,
   input  logic              memWrite3,
   input  logic              memRead3,
   input  logic              branch3,
   input  logic              aluZero,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] rdData2_3,
   input  logic [DATA_W-1:0] adder2,
   input  logic [REG_AW-1:0] mux3Out,
   input  logic              flush,
   output logic              stall,
   output logic              pcSrc,
   output logic [DATA_W-1:0] branchTarget,
   mem_stage_if.master       dmem,
   output logic              regWrite4,
   output logic              memtoReg4,
   output logic [DATA_W-1:0] memReadData4,
   output logic [DATA_W-1:0] aluResult4,
   output logic [REG_AW-1:0] writeReg4,
   output logic              memErr
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   typedef struct packed {
      logic              regWrite;
      logic              memtoReg;
      logic              memWrite;
      logic              memRead;
      logic              branch;
      logic              aluZero;
      logic [DATA_W-1:0] aluResult;
      logic [DATA_W-1:0] rdData2;
      logic [DATA_W-1:0] adder2;
      logic [REG_AW-1:0] writeReg;
   } ex_mem_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   ex_mem_t           r_em, w_em_in;
   logic              r_regWrite4, r_memtoReg4, r_memErr;
   logic [DATA_W-1:0] r_memReadData4, r_aluResult4;
   logic [REG_AW-1:0] r_writeReg4;
   logic              w_access, w_timeout, w_stall, w_rd_done;

   // Next-state, stall and timeout decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_access    = (r_state == S_ACCESS);
      w_timeout   = w_access & ~dmem.dmem_ack & (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
      w_stall     = w_access & ~dmem.dmem_ack & ~w_timeout;
      w_rd_done   = w_access & dmem.dmem_ack & r_em.memRead & ~r_em.memWrite;
      w_em_in     = '0;
      if (!flush) begin
         w_em_in = '{regWrite: regWrite3, memtoReg: memtoReg3, memWrite: memWrite3,
                     memRead: memRead3, branch: branch3, aluZero: aluZero,
                     aluResult: aluResult, rdData2: rdData2_3, adder2: adder2,
                     writeReg: mux3Out};
      end
      if (w_stall) begin
         w_state_nxt = S_ACCESS;
         w_cnt_nxt   = r_cnt + CNT_W'(1);
      end else begin
         w_state_nxt = (w_em_in.memRead | w_em_in.memWrite) ? S_ACCESS : S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Pipeline registers advance together whenever the stage is not stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_em           <= '0;
         r_regWrite4    <= 1'b0;
         r_memtoReg4    <= 1'b0;
         r_memReadData4 <= '0;
         r_aluResult4   <= '0;
         r_writeReg4    <= '0;
         r_memErr       <= 1'b0;
      end else begin
         if (w_timeout) r_memErr <= 1'b1;
         if (!w_stall) begin
            r_em           <= w_em_in;
            r_regWrite4    <= r_em.regWrite & ~w_timeout;
            r_memtoReg4    <= r_em.memtoReg;
            r_memReadData4 <= w_rd_done ? dmem.dmem_rdata : '0;
            r_aluResult4   <= r_em.aluResult;
            r_writeReg4    <= r_em.writeReg;
         end
      end
   end

   assign dmem.dmem_req   = w_access;
   assign dmem.dmem_we    = r_em.memWrite;
   assign dmem.dmem_addr  = r_em.aluResult;
   assign dmem.dmem_wdata = r_em.rdData2;

   assign stall        = w_stall;
   assign pcSrc        = r_em.branch & r_em.aluZero;
   assign branchTarget = r_em.adder2;
   assign regWrite4    = r_regWrite4;
   assign memtoReg4    = r_memtoReg4;
   assign memReadData4 = r_memReadData4;
   assign aluResult4   = r_aluResult4;
   assign writeReg4    = r_writeReg4;
   assign memErr       = r_memErr;

endmodule
